// File: rtl/desc_pkg.sv
// Shared SGDMA descriptor layout constants and the chain-builder FSM state type.
// The VERIFY state exists only when DESC_CHAIN_BUILDER_READBACK_EN is defined.
package desc_pkg;

   localparam int DESC_WORDS = 8;

   localparam logic [2:0] W_SRC  = 3'd0;
   localparam logic [2:0] W_DST  = 3'd2;
   localparam logic [2:0] W_NEXT = 3'd4;
   localparam logic [2:0] W_LEN  = 3'd6;
   localparam logic [2:0] W_CTRL = 3'd7;

   localparam int CTRL_OWNED_BY_HW = 7;
   localparam int CTRL_GEN_EOP     = 0;

`ifdef DESC_CHAIN_BUILDER_READBACK_EN
   typedef enum logic [1:0] {IDLE, WRITE, VERIFY, FINISH} state_t;
`else
   typedef enum logic [1:0] {IDLE, WRITE, FINISH} state_t;
`endif

endpackage

// File: rtl/desc_word_gen.sv
// Combinational descriptor word generator shared by the writer and the readback checker.
// Terminator descriptors are all-zero apart from a next pointer that points at themselves.
module desc_word_gen
   import desc_pkg::*;
#(
   parameter logic [13:0] DESC_BASE      = 14'd0,
   parameter logic [31:0] DESC_PHYS_BASE = 32'h0000_0000
) (
   input  logic [10:0] desc_idx_i,
   input  logic [2:0]  word_idx_i,
   input  logic [31:0] src_i,
   input  logic [31:0] dst_i,
   input  logic [15:0] line_bytes_i,
   input  logic        is_last_i,
   input  logic        is_term_i,
   output logic [31:0] word_o
);

   logic [31:0] target_idx;
   logic [31:0] next_ptr;
   logic [7:0]  ctrl;

   always_comb begin
      target_idx = {21'd0, desc_idx_i} + (is_term_i ? 32'd0 : 32'd1);
      // Word address -> SGDMA byte address: 8 words per descriptor, 4 bytes per word.
      next_ptr   = DESC_PHYS_BASE + ((32'(DESC_BASE) + (target_idx << 3)) << 2);

      ctrl                   = '0;
      ctrl[CTRL_OWNED_BY_HW] = 1'b1;
      ctrl[CTRL_GEN_EOP]     = is_last_i;

      word_o = '0;
      if (is_term_i) begin
         if (word_idx_i == W_NEXT) begin
            word_o = next_ptr;
         end
      end else begin
         case (word_idx_i)
            W_SRC:   word_o = src_i;
            W_DST:   word_o = dst_i;
            W_NEXT:  word_o = next_ptr;
            W_LEN:   word_o = {16'h0, line_bytes_i};
            W_CTRL:  word_o = {ctrl, 24'h0};
            default: word_o = '0;
         endcase
      end
   end

endmodule

// File: rtl/desc_chain_builder.sv
// Avalon-MM write master that fills SGDMA descriptor memory with one descriptor per line plus a terminator.
// Optional readback check of the written chain: DESC_CHAIN_BUILDER_READBACK_EN.
module desc_chain_builder
   import desc_pkg::*;
#(
   parameter logic [13:0] DESC_BASE      = 14'd0,
   parameter logic [31:0] DESC_PHYS_BASE = 32'h0000_0000,
   parameter int unsigned MAX_LINES      = 2047,
   parameter int unsigned MEM_WORDS      = 16384
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [31:0] cfg_src_base,
   input  logic [31:0] cfg_stride,
   input  logic [31:0] cfg_dst_addr,
   input  logic [15:0] cfg_line_bytes,
   input  logic [10:0] cfg_num_lines,
   output logic        busy,
   output logic        done,
   output logic        cfg_err,
   output logic        verify_err,
   output logic [13:0] mem_address,
   output logic [3:0]  mem_byteenable,
   output logic        mem_chipselect,
   output logic        mem_write,
   output logic [31:0] mem_writedata,
   output logic        mem_clken,
   input  logic [31:0] mem_readdata
);

   localparam logic [2:0] LAST_WORD = 3'(DESC_WORDS - 1);

   state_t      state_q;
   logic        busy_q;
   logic        done_q;
   logic        cfg_err_q;
   logic        cs_q;
   logic        we_q;
   logic [13:0] addr_q;
   logic [10:0] desc_idx_q;
   logic [2:0]  word_idx_q;
   logic [31:0] src_q;
   logic [31:0] stride_q;
   logic [31:0] dst_q;
   logic [15:0] len_q;
   logic [10:0] n_q;

   logic [31:0] span_end;
   logic        cfg_ok;
   logic        is_last;
   logic        is_term;
   logic        last_word;
   logic [31:0] gen_src;
   logic [31:0] gen_word;

`ifdef DESC_CHAIN_BUILDER_READBACK_EN
   logic [31:0] src_base_q;
   logic [31:0] vsrc_q;
   logic [31:0] exp_q;
   logic        chk_q;
   logic        verr_q;
`endif

   always_comb begin
      span_end = 32'(DESC_BASE) + ((32'(cfg_num_lines) + 32'd1) * 32'(DESC_WORDS));
      cfg_ok   = (cfg_num_lines != 11'd0) && (cfg_line_bytes != 16'd0) &&
                 (32'(cfg_num_lines) <= MAX_LINES) && (span_end <= MEM_WORDS);
   end

   assign is_last   = (desc_idx_q == n_q - 11'd1);
   assign is_term   = (desc_idx_q == n_q);
   assign last_word = is_term && (word_idx_q == LAST_WORD);

`ifdef DESC_CHAIN_BUILDER_READBACK_EN
   assign gen_src = (state_q == VERIFY) ? vsrc_q : src_q;
`else
   assign gen_src = src_q;
`endif

   desc_word_gen #(
      .DESC_BASE      (DESC_BASE),
      .DESC_PHYS_BASE (DESC_PHYS_BASE)
   ) u_word_gen (
      .desc_idx_i   (desc_idx_q),
      .word_idx_i   (word_idx_q),
      .src_i        (gen_src),
      .dst_i        (dst_q),
      .line_bytes_i (len_q),
      .is_last_i    (is_last),
      .is_term_i    (is_term),
      .word_o       (gen_word)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         cfg_err_q  <= 1'b0;
         cs_q       <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         desc_idx_q <= '0;
         word_idx_q <= '0;
         src_q      <= '0;
         stride_q   <= '0;
         dst_q      <= '0;
         len_q      <= '0;
         n_q        <= '0;
`ifdef DESC_CHAIN_BUILDER_READBACK_EN
         src_base_q <= '0;
         vsrc_q     <= '0;
         exp_q      <= '0;
         chk_q      <= 1'b0;
         verr_q     <= 1'b0;
`endif
      end else begin
         done_q    <= 1'b0;
         cfg_err_q <= 1'b0;
`ifdef DESC_CHAIN_BUILDER_READBACK_EN
         // Read data lags the address by one cycle, so compare against last cycle's expectation.
         chk_q <= 1'b0;
         if (chk_q && (mem_readdata != exp_q)) begin
            verr_q <= 1'b1;
         end
`endif
         case (state_q)
            IDLE: begin
               if (start) begin
                  src_q      <= cfg_src_base;
                  stride_q   <= cfg_stride;
                  dst_q      <= cfg_dst_addr;
                  len_q      <= cfg_line_bytes;
                  n_q        <= cfg_num_lines;
                  desc_idx_q <= '0;
                  word_idx_q <= '0;
                  addr_q     <= DESC_BASE;
`ifdef DESC_CHAIN_BUILDER_READBACK_EN
                  src_base_q <= cfg_src_base;
`endif
                  if (cfg_ok) begin
                     state_q <= WRITE;
                     busy_q  <= 1'b1;
                     cs_q    <= 1'b1;
                     we_q    <= 1'b1;
`ifdef DESC_CHAIN_BUILDER_READBACK_EN
                     verr_q  <= 1'b0;
`endif
                  end else begin
                     cfg_err_q <= 1'b1;
                  end
               end
            end

            WRITE: begin
               addr_q     <= addr_q + 14'd1;
               word_idx_q <= word_idx_q + 3'd1;
               if (word_idx_q == LAST_WORD) begin
                  desc_idx_q <= desc_idx_q + 11'd1;
                  src_q      <= src_q + stride_q;
               end
               if (last_word) begin
                  addr_q     <= DESC_BASE;
                  desc_idx_q <= '0;
                  we_q       <= 1'b0;
`ifdef DESC_CHAIN_BUILDER_READBACK_EN
                  state_q    <= VERIFY;
                  vsrc_q     <= src_base_q;
`else
                  state_q    <= FINISH;
                  cs_q       <= 1'b0;
                  busy_q     <= 1'b0;
                  done_q     <= 1'b1;
`endif
               end
            end

`ifdef DESC_CHAIN_BUILDER_READBACK_EN
            VERIFY: begin
               if (cs_q) begin
                  exp_q      <= gen_word;
                  chk_q      <= 1'b1;
                  addr_q     <= addr_q + 14'd1;
                  word_idx_q <= word_idx_q + 3'd1;
                  if (word_idx_q == LAST_WORD) begin
                     desc_idx_q <= desc_idx_q + 11'd1;
                     vsrc_q     <= vsrc_q + stride_q;
                  end
                  if (last_word) begin
                     cs_q       <= 1'b0;
                     addr_q     <= DESC_BASE;
                     desc_idx_q <= '0;
                  end
               end else begin
                  // Drain cycle: the final read word is compared on this edge.
                  state_q <= FINISH;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
`endif

            FINISH: begin
               state_q <= IDLE;
            end

            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy           = busy_q;
   assign done           = done_q;
   assign cfg_err        = cfg_err_q;
   assign mem_address    = addr_q;
   assign mem_byteenable = 4'hF;
   assign mem_chipselect = cs_q;
   assign mem_write      = we_q;
   assign mem_writedata  = we_q ? gen_word : 32'd0;
   assign mem_clken      = 1'b1;

`ifdef DESC_CHAIN_BUILDER_READBACK_EN
   assign verify_err = verr_q;
`else
   logic unused_readdata;
   assign unused_readdata = ^mem_readdata;
   assign verify_err      = 1'b0;
`endif

   a_addr_in_chain: assert property (@(posedge clk) disable iff (!reset_n)
      cs_q |-> (32'(addr_q) < 32'(DESC_BASE) + ((32'(n_q) + 32'd1) << 3)));

   a_done_not_busy: assert property (@(posedge clk) disable iff (!reset_n)
      done_q |-> !busy_q);

endmodule

// File: tb/tb_desc_chain_builder.sv
// Scoreboard bench for desc_chain_builder: expected writes/done/cfg_err are queued by stimulus and popped by a monitor.
// MAX_LINES is overridden to 4 so the line-count limit is reachable through the 11-bit cfg_num_lines port.
module tb_desc_chain_builder;

   localparam logic [13:0] TB_DESC_BASE = 14'd0;
   localparam logic [31:0] TB_PHYS      = 32'h0000_0000;
   localparam int unsigned TB_MAX_LINES = 4;
`ifdef DESC_CHAIN_BUILDER_READBACK_EN
   localparam int RB_EXTRA = 1;
`else
   localparam int RB_EXTRA = 0;
`endif

   typedef struct packed {
      logic [13:0] addr;
      logic [31:0] data;
   } wr_t;

   typedef struct packed {
      logic [31:0] cyc;
      logic        verr;
   } dn_t;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic [31:0] cfg_src_base = '0;
   logic [31:0] cfg_stride = '0;
   logic [31:0] cfg_dst_addr = '0;
   logic [15:0] cfg_line_bytes = '0;
   logic [10:0] cfg_num_lines = '0;
   logic        busy, done, cfg_err, verify_err;
   logic [13:0] mem_address;
   logic [3:0]  mem_byteenable;
   logic        mem_chipselect, mem_write, mem_clken;
   logic [31:0] mem_writedata;
   logic [31:0] mem_readdata = '0;

   logic [31:0] mem [0:63];
   logic        corrupt = 1'b0;
   logic [31:0] cyc = '0;

   wr_t         wq[$];
   dn_t         dq[$];
   logic [31:0] cq[$];
   int          checks = 0;
   int          fails = 0;

   always #5 clk = ~clk;

   desc_chain_builder #(
      .DESC_BASE      (TB_DESC_BASE),
      .DESC_PHYS_BASE (TB_PHYS),
      .MAX_LINES      (TB_MAX_LINES),
      .MEM_WORDS      (16384)
   ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .start          (start),
      .cfg_src_base   (cfg_src_base),
      .cfg_stride     (cfg_stride),
      .cfg_dst_addr   (cfg_dst_addr),
      .cfg_line_bytes (cfg_line_bytes),
      .cfg_num_lines  (cfg_num_lines),
      .busy           (busy),
      .done           (done),
      .cfg_err        (cfg_err),
      .verify_err     (verify_err),
      .mem_address    (mem_address),
      .mem_byteenable (mem_byteenable),
      .mem_chipselect (mem_chipselect),
      .mem_write      (mem_write),
      .mem_writedata  (mem_writedata),
      .mem_clken      (mem_clken),
      .mem_readdata   (mem_readdata)
   );

   // Descriptor memory model; optionally corrupts word 5 as it is stored.
   always @(posedge clk) begin
      cyc <= cyc + 32'd1;
      if (mem_chipselect && mem_write)
         mem[mem_address[5:0]] <= (corrupt && mem_address == 14'd5) ? (mem_writedata ^ 32'd1) : mem_writedata;
      if (mem_chipselect)
         mem_readdata <= mem[mem_address[5:0]];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] exp_word(input int d, input int w, input int n,
                                            input logic [31:0] src, input logic [31:0] stride,
                                            input logic [31:0] dst, input logic [15:0] len);
      logic [31:0] s;
      bit          term;
      s    = src + stride * 32'(d);
      term = (d == n);
      case (w)
         0:       return term ? 32'd0 : s;
         2:       return term ? 32'd0 : dst;
         4:       return TB_PHYS + ((32'(TB_DESC_BASE) + 32'(8 * (term ? d : d + 1))) << 2);
         6:       return term ? 32'd0 : {16'h0, len};
         7:       return term ? 32'd0 : ((d == n - 1) ? 32'h8100_0000 : 32'h8000_0000);
         default: return 32'd0;
      endcase
   endfunction

   task automatic build(input logic [31:0] src, input logic [31:0] stride, input logic [31:0] dst,
                        input logic [15:0] len, input int n, input logic verr_exp);
      logic [31:0] s;
      int          m;
      wr_t         e;
      dn_t         de;
      @(negedge clk);
      cfg_src_base   = src;
      cfg_stride     = stride;
      cfg_dst_addr   = dst;
      cfg_line_bytes = len;
      cfg_num_lines  = 11'(n);
      start          = 1'b1;
      s              = cyc;
      for (int d = 0; d <= n; d++) begin
         for (int w = 0; w < 8; w++) begin
            e.addr = 14'(32'(TB_DESC_BASE) + 32'(d * 8 + w));
            e.data = exp_word(d, w, n, src, stride, dst, len);
            wq.push_back(e);
         end
      end
      m       = (n + 1) * 8;
      de.cyc  = s + 32'(m + 1) + 32'(RB_EXTRA * (m + 1));
      de.verr = verr_exp;
      dq.push_back(de);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic reject(input logic [15:0] len, input int n);
      @(negedge clk);
      cfg_src_base   = 32'h1000_0000;
      cfg_stride     = 32'd640;
      cfg_line_bytes = len;
      cfg_num_lines  = 11'(n);
      start          = 1'b1;
      cq.push_back(cyc + 32'd1);
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("busy_after_reject", {31'd0, busy}, 32'd0);
      end
   endtask

   task automatic drain(input int budget, input string name);
      int i;
      for (i = 0; i < budget; i++) begin
         @(posedge clk);
         if (wq.size() == 0 && dq.size() == 0 && cq.size() == 0) break;
      end
      checks++;
      if (i == budget) begin
         fails++;
         $display("FAIL %s_timeout: %0d writes, %0d done, %0d cfg_err still pending, required 0",
                  name, wq.size(), dq.size(), cq.size());
         wq.delete();
         dq.delete();
         cq.delete();
      end
   endtask

   always @(negedge clk) begin
      if (reset_n) begin
         if (mem_chipselect && mem_write) begin
            if (wq.size() == 0) begin
               checks++;
               fails++;
               $display("FAIL unexpected_write: addr 0x%0h data 0x%08h, required no write", mem_address, mem_writedata);
            end else begin
               wr_t e;
               e = wq.pop_front();
               chk("wr_addr", {18'd0, mem_address}, {18'd0, e.addr});
               chk("wr_data", mem_writedata, e.data);
            end
         end
         if (done) begin
            if (dq.size() == 0) begin
               checks++;
               fails++;
               $display("FAIL unexpected_done: at cycle %0d, required none", cyc);
            end else begin
               dn_t d;
               d = dq.pop_front();
               chk("done_cycle", cyc, d.cyc);
               chk("verify_err_at_done", {31'd0, verify_err}, {31'd0, d.verr});
               chk("busy_at_done", {31'd0, busy}, 32'd0);
            end
         end
         if (cfg_err) begin
            if (cq.size() == 0) begin
               checks++;
               fails++;
               $display("FAIL unexpected_cfg_err: at cycle %0d, required none", cyc);
            end else begin
               logic [31:0] c;
               c = cq.pop_front();
               chk("cfg_err_cycle", cyc, c);
            end
         end
      end
   end

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_busy"},       {31'd0, busy}, 32'd0);
      chk({tag, "_done"},       {31'd0, done}, 32'd0);
      chk({tag, "_cfg_err"},    {31'd0, cfg_err}, 32'd0);
      chk({tag, "_verify_err"}, {31'd0, verify_err}, 32'd0);
      chk({tag, "_cs"},         {31'd0, mem_chipselect}, 32'd0);
      chk({tag, "_we"},         {31'd0, mem_write}, 32'd0);
      chk({tag, "_addr"},       {18'd0, mem_address}, 32'd0);
      chk({tag, "_wdata"},      mem_writedata, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, %0d writes pending", wq.size());
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      chk_reset_outputs("reset");
      chk("reset_byteenable", {28'd0, mem_byteenable}, 32'h0000_000F);
      chk("reset_clken", {31'd0, mem_clken}, 32'd1);
      reset_n = 1'b1;

      // Three 640-byte lines, then spot checks of the stored chain.
      build(32'h1000_0000, 32'd640, 32'd0, 16'd640, 3, 1'b0);
      drain(200, "n3");
      chk("n3_desc1_w0", mem[8], 32'h1000_0280);
      chk("n3_desc0_w4", mem[4], 32'h0000_0020);
      chk("n3_desc0_w6", mem[6], 32'h0000_0280);
      chk("n3_desc2_w7", mem[23], 32'h8100_0000);
      chk("n3_desc1_w7", mem[15], 32'h8000_0000);
      chk("n3_term_w7", mem[31], 32'h0000_0000);
      chk("n3_term_w4", mem[28], 32'h0000_0060);

      // Rejected configurations: zero lines, zero bytes, too many lines.
      reject(16'd640, 0);
      reject(16'd0, 3);
      reject(16'd640, 5);
      drain(20, "reject");

      // Source address wraps at 32 bits.
      build(32'hFFFF_FE00, 32'h0000_0400, 32'h2000_0000, 16'd128, 2, 1'b0);
      drain(200, "wrap");
      chk("wrap_desc1_w0", mem[8], 32'h0000_0200);
      chk("wrap_desc1_w2", mem[10], 32'h2000_0000);

      // Asynchronous reset while write 10 of an N=4 build is on the bus.
      build(32'h3000_0000, 32'h0000_0100, 32'd0, 16'd64, 4, 1'b0);
      repeat (10) @(posedge clk);
      #2 reset_n = 1'b0;
      #1 chk_reset_outputs("midrst");
      chk("midrst_writes_seen", 32'(wq.size()), 32'd30);
      wq.delete();
      dq.delete();
      @(negedge clk);
      reset_n = 1'b1;
      build(32'h3000_0000, 32'h0000_0100, 32'd0, 16'd64, 4, 1'b0);
      drain(300, "rebuild");

      // A start pulse (with different config) during a build is ignored.
      build(32'h4000_0000, 32'h0000_0040, 32'h5000_0000, 16'd32, 2, 1'b0);
      repeat (4) @(negedge clk);
      chk("busy_mid_build", {31'd0, busy}, 32'd1);
      cfg_src_base  = 32'h0;
      cfg_num_lines = 11'd1;
      start         = 1'b1;
      @(negedge clk);
      start = 1'b0;
      drain(200, "busy_start");

`ifdef DESC_CHAIN_BUILDER_READBACK_EN
      corrupt = 1'b1;
      build(32'h6000_0000, 32'h0000_0080, 32'd0, 16'd16, 1, 1'b1);
      drain(200, "rb_corrupt");
      corrupt = 1'b0;
      build(32'h6000_0000, 32'h0000_0080, 32'd0, 16'd16, 1, 1'b0);
      drain(200, "rb_clean");
`endif

      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
